// File: rtl/rvc_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rvc_fetch_pkg
//  Description : Shared types and constants for the RV32IC fetch stage and
//                the ID stage that consumes the IF/ID register.
//  Revision    : 1.0 - initial release
// ============================================================================
package rvc_fetch_pkg;

  // Fetch FSM: RUN fetches normally, PEND parks a redirect behind a miss
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } fetch_state_t;

  // PC increments for full-width and compressed instructions
  localparam logic [31:0] INC_RV32 = 32'd4;
  localparam logic [31:0] INC_RVC  = 32'd2;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instr;
    logic        is_rvc;
  } ifid_t;

endpackage : rvc_fetch_pkg
`default_nettype wire

// File: rtl/fetch_perf_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_perf_ctr
//  Description : Free-running enable counter with synchronous reset; wraps
//                silently at 2^CNT_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_perf_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: increment when enabled, otherwise hold
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + C_ONE;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : fetch_perf_ctr
`default_nettype wire

// File: rtl/rvc_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : rvc_fetch_stage
//  Description : IF stage for the RV32IC pipeline. Owns the PC, drives the
//                RVC I-cache with a halfword address, fills IF/ID and parks
//                EX redirects that arrive while a miss is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvc_fetch_stage
  import rvc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             proc_reset,
  output logic             icache_read,
  output logic [30:0]      icache_addr,
  input  logic [31:0]      icache_rdata,
  input  logic             icache_stall,
  input  logic             icache_pcadd,
  input  logic             pipe_stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             ifid_valid,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_pc_next,
  output logic [31:0]      ifid_instr,
  output logic             ifid_is_rvc,
  output logic [CNT_W-1:0] perf_fetched,
  output logic [CNT_W-1:0] perf_rvc
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_buf_q, redir_buf_d;
  logic         fetch_en_q;
  ifid_t        ifid_q, ifid_d;

  logic         w_accept;
  logic [31:0]  w_inc;
  logic [31:0]  w_pc_inc;
  logic [31:0]  w_target;
  logic         w_cnt_en;

  // Redirect targets are always halfword aligned; bit 0 is forced low
  assign w_target = redirect_pc & 32'hFFFF_FFFE;
  assign w_inc    = icache_pcadd ? INC_RV32 : INC_RVC;
  assign w_pc_inc = pc_q + w_inc;
  assign w_accept = fetch_en_q & ~icache_stall & ~pipe_stall;

  // PC mux, redirect parking FSM and IF/ID load
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_buf_d = redir_buf_q;
    ifid_d      = ifid_q;
    w_cnt_en    = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect_valid && !icache_stall) begin
          pc_d         = w_target;
          ifid_d.valid = 1'b0;
        end else if (redirect_valid) begin
          // Miss in flight: the cache still reads the old address, so the
          // target waits in redir_buf until the miss resolves
          redir_buf_d  = w_target;
          state_d      = PEND;
          ifid_d.valid = 1'b0;
        end else if (w_accept) begin
          ifid_d.valid   = 1'b1;
          ifid_d.pc      = pc_q;
          ifid_d.pc_next = w_pc_inc;
          ifid_d.instr   = icache_rdata;
          ifid_d.is_rvc  = ~icache_pcadd;
          pc_d           = w_pc_inc;
          w_cnt_en       = 1'b1;
        end
      end
      PEND: begin
        // The word returned for the stale address is dropped
        ifid_d.valid = 1'b0;
        if (redirect_valid) begin
          redir_buf_d = w_target;
        end
        if (!icache_stall) begin
          pc_d    = redirect_valid ? w_target : redir_buf_q;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, PC, fetch enable and IF/ID registers
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      redir_buf_q <= RESET_PC;
      fetch_en_q  <= 1'b0;
      ifid_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redir_buf_q <= redir_buf_d;
      fetch_en_q  <= 1'b1;
      ifid_q      <= ifid_d;
    end
  end

  fetch_perf_ctr #(.CNT_W(CNT_W)) u_ctr_fetched (
    .clk   (clk),
    .rst   (proc_reset),
    .en    (w_cnt_en),
    .count (perf_fetched)
  );

  fetch_perf_ctr #(.CNT_W(CNT_W)) u_ctr_rvc (
    .clk   (clk),
    .rst   (proc_reset),
    .en    (w_cnt_en & ~icache_pcadd),
    .count (perf_rvc)
  );

  assign icache_read  = fetch_en_q;
  assign icache_addr  = pc_q[31:1];
  assign ifid_valid   = ifid_q.valid;
  assign ifid_pc      = ifid_q.pc;
  assign ifid_pc_next = ifid_q.pc_next;
  assign ifid_instr   = ifid_q.instr;
  assign ifid_is_rvc  = ifid_q.is_rvc;

endmodule : rvc_fetch_stage
`default_nettype wire
